// File: rtl/reorder_buffer.sv
// Circular in-order reorder buffer.
// Issue allocates entries at the tail and receives a tag. Completion writes
// results by tag. Finished entries retire in program order from the head
// through a valid/ready handshake. Tag 0 means "no entry"; live tags are
// 1..ROBsize, and tag t lives in storage slot t-1.
module reorder_buffer #(
  parameter int ROBsize    = 32,
  parameter int ROBsizeLog = $clog2(ROBsize + 1),
  parameter int addrSize   = $clog2(ROBsize)
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  flush_i,
  // allocation (issue side)
  input  logic                  alloc_valid_i,
  input  logic [4:0]            alloc_destReg_i,
  input  logic                  alloc_setsFlags_i,
  output logic                  alloc_ready_o,
  output logic [ROBsizeLog-1:0] alloc_tag_o,
  // completion write port
  input  logic [addrSize:0]     ROBWriteAddr_i,
  input  logic                  ROBWriteEn_i,
  input  logic [69:0]           ROBWriteData_i,
  // retirement (commit side)
  output logic                  commit_valid_o,
  input  logic                  commit_ready_i,
  output logic [ROBsizeLog-1:0] commit_tag_o,
  output logic [4:0]            commit_destReg_o,
  output logic [63:0]           commit_data_o,
  output logic                  commit_flagsWe_o,
  output logic [3:0]            commit_flags_o,
  output logic [ROBsizeLog-1:0] count_o
);

  localparam logic [ROBsizeLog-1:0] LP_MAX_TAG  = ROBsizeLog'(ROBsize);
  localparam logic [ROBsizeLog-1:0] LP_ONE_TAG  = ROBsizeLog'(1);
  localparam logic [addrSize:0]     LP_MAX_ADDR = (addrSize + 1)'(ROBsize);

  // Control state: validity bits and pointers, all cleared by reset/flush.
  logic [ROBsize-1:0]    r_busy;
  logic [ROBsize-1:0]    r_dvalid;
  logic [ROBsize-1:0]    r_fvalid;
  logic [ROBsizeLog-1:0] r_head;
  logic [ROBsizeLog-1:0] r_tail;
  logic [ROBsizeLog-1:0] r_count;

  // Payload storage; meaningful only while the matching busy bit is set.
  logic [4:0]  r_dest  [ROBsize];
  logic        r_sflag [ROBsize];
  logic [63:0] r_data  [ROBsize];
  logic [3:0]  r_flags [ROBsize];

  logic [addrSize-1:0] w_head_idx;
  logic [addrSize-1:0] w_tail_idx;
  logic [addrSize-1:0] w_wr_idx;
  logic                w_wr_ok;
  logic                w_alloc_fire;
  logic                w_commit_fire;
  logic                w_head_ready;
  logic                w_clear;

  // Pointers wrap ROBsize -> 1 so tag 0 is never produced.
  function automatic logic [ROBsizeLog-1:0] f_next(input logic [ROBsizeLog-1:0] p);
    return (p == LP_MAX_TAG) ? LP_ONE_TAG : p + LP_ONE_TAG;
  endfunction

  // Address decode, fire strobes and head-entry readout.
  always_comb begin
    w_clear       = reset_i || flush_i;
    w_head_idx    = addrSize'(r_head - LP_ONE_TAG);
    w_tail_idx    = addrSize'(r_tail - LP_ONE_TAG);
    w_wr_idx      = addrSize'(ROBWriteAddr_i - 1'b1);
    // Range check guards the truncated index, so out-of-range tags never alias.
    w_wr_ok       = ROBWriteEn_i && (ROBWriteAddr_i != '0)
                    && (ROBWriteAddr_i <= LP_MAX_ADDR) && r_busy[w_wr_idx];
    w_head_ready  = (r_count != '0) && r_busy[w_head_idx] && r_dvalid[w_head_idx]
                    && (!r_sflag[w_head_idx] || r_fvalid[w_head_idx]);
    w_alloc_fire  = alloc_valid_i && alloc_ready_o;
    w_commit_fire = w_head_ready && commit_ready_i;

    alloc_ready_o    = (r_count < LP_MAX_TAG);
    alloc_tag_o      = r_tail;
    commit_valid_o   = w_head_ready;
    commit_tag_o     = r_head;
    commit_destReg_o = r_dest[w_head_idx];
    commit_data_o    = r_data[w_head_idx];
    commit_flagsWe_o = r_sflag[w_head_idx] && r_fvalid[w_head_idx];
    commit_flags_o   = r_flags[w_head_idx];
    count_o          = r_count;
  end

  // Control update; reset and flush win over every other action in the cycle.
  always_ff @(posedge clk_i) begin
    if (w_clear) begin
      r_busy   <= '0;
      r_dvalid <= '0;
      r_fvalid <= '0;
      r_head   <= LP_ONE_TAG;
      r_tail   <= LP_ONE_TAG;
      r_count  <= '0;
    end else begin
      if (w_wr_ok) begin
        r_dvalid[w_wr_idx] <= ROBWriteData_i[64];
        if (ROBWriteData_i[69]) begin
          r_fvalid[w_wr_idx] <= 1'b1;
        end
      end
      if (w_commit_fire) begin
        r_busy[w_head_idx] <= 1'b0;
        r_head             <= f_next(r_head);
      end
      // The tail slot is never busy, so it cannot collide with a write or retire.
      if (w_alloc_fire) begin
        r_busy[w_tail_idx]   <= 1'b1;
        r_dvalid[w_tail_idx] <= 1'b0;
        r_fvalid[w_tail_idx] <= 1'b0;
        r_tail               <= f_next(r_tail);
      end
      if (w_alloc_fire && !w_commit_fire) begin
        r_count <= r_count + LP_ONE_TAG;
      end else if (!w_alloc_fire && w_commit_fire) begin
        r_count <= r_count - LP_ONE_TAG;
      end
    end
  end

  // Payload update; no reset needed because validity bits gate every use.
  always_ff @(posedge clk_i) begin
    if (!w_clear) begin
      if (w_wr_ok) begin
        r_data[w_wr_idx] <= ROBWriteData_i[63:0];
        if (ROBWriteData_i[69]) begin
          r_flags[w_wr_idx] <= ROBWriteData_i[68:65];
        end
      end
      if (w_alloc_fire) begin
        r_dest[w_tail_idx]  <= alloc_destReg_i;
        r_sflag[w_tail_idx] <= alloc_setsFlags_i;
      end
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed testbench for reorder_buffer: allocation, out-of-order completion,
// flag dependency, full/wrap, illegal writes and flush.
module tb_reorder_buffer;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        flush_i;
  logic        alloc_valid_i;
  logic [4:0]  alloc_destReg_i;
  logic        alloc_setsFlags_i;
  logic        alloc_ready_o;
  logic [5:0]  alloc_tag_o;
  logic [5:0]  ROBWriteAddr_i;
  logic        ROBWriteEn_i;
  logic [69:0] ROBWriteData_i;
  logic        commit_valid_o;
  logic        commit_ready_i;
  logic [5:0]  commit_tag_o;
  logic [4:0]  commit_destReg_o;
  logic [63:0] commit_data_o;
  logic        commit_flagsWe_o;
  logic [3:0]  commit_flags_o;
  logic [5:0]  count_o;

  int total = 0;
  int bad   = 0;

  reorder_buffer #(.ROBsize(32)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .flush_i(flush_i),
    .alloc_valid_i(alloc_valid_i), .alloc_destReg_i(alloc_destReg_i),
    .alloc_setsFlags_i(alloc_setsFlags_i), .alloc_ready_o(alloc_ready_o),
    .alloc_tag_o(alloc_tag_o), .ROBWriteAddr_i(ROBWriteAddr_i),
    .ROBWriteEn_i(ROBWriteEn_i), .ROBWriteData_i(ROBWriteData_i),
    .commit_valid_o(commit_valid_o), .commit_ready_i(commit_ready_i),
    .commit_tag_o(commit_tag_o), .commit_destReg_o(commit_destReg_o),
    .commit_data_o(commit_data_o), .commit_flagsWe_o(commit_flagsWe_o),
    .commit_flags_o(commit_flags_o), .count_o(count_o)
  );

  always #5 clk_i = ~clk_i;

  // Advance one edge; outputs are then sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    flush_i = 1'b0; alloc_valid_i = 1'b0; alloc_destReg_i = '0;
    alloc_setsFlags_i = 1'b0; ROBWriteAddr_i = '0; ROBWriteEn_i = 1'b0;
    ROBWriteData_i = '0; commit_ready_i = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
  endtask

  task automatic set_wr(input logic [5:0] tag, input logic [63:0] d, input logic dv,
                        input logic [3:0] f, input logic fv);
    ROBWriteEn_i   = 1'b1;
    ROBWriteAddr_i = tag;
    ROBWriteData_i = {fv, f, dv, d};
  endtask

  task automatic clr_wr();
    ROBWriteEn_i = 1'b0; ROBWriteAddr_i = '0; ROBWriteData_i = '0;
  endtask

  task automatic alloc_one(input logic [4:0] dst, input logic sf);
    alloc_valid_i = 1'b1; alloc_destReg_i = dst; alloc_setsFlags_i = sf;
    tick();
    alloc_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (count_o !== 6'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count_o); end
    total++; if (alloc_ready_o !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", alloc_ready_o); end
    total++; if (alloc_tag_o !== 6'd1) begin bad++; $display("FAIL reset_tag got=%0d exp=1", alloc_tag_o); end
    total++; if (commit_valid_o !== 1'b0) begin bad++; $display("FAIL reset_cvalid got=%b exp=0", commit_valid_o); end
    for (int i = 0; i < 3; i++) begin
      total++;
      if (alloc_tag_o !== 6'(i + 1)) begin bad++; $display("FAIL alloc_tag%0d got=%0d exp=%0d", i, alloc_tag_o, i + 1); end
      alloc_one(5'(i + 1), 1'b0);
    end
    total++; if (count_o !== 6'd3) begin bad++; $display("FAIL alloc3_count got=%0d exp=3", count_o); end
  endtask

  task automatic test_out_of_order();
    do_reset();
    alloc_one(5'd5, 1'b0);
    alloc_one(5'd6, 1'b0);
    set_wr(6'd2, 64'hB, 1'b1, 4'h0, 1'b0);
    tick();
    clr_wr();
    total++; if (commit_valid_o !== 1'b0) begin bad++; $display("FAIL ooo_head_blocked got=%b exp=0", commit_valid_o); end
    set_wr(6'd1, 64'hA, 1'b1, 4'h0, 1'b0);
    #1;
    total++; if (commit_valid_o !== 1'b0) begin bad++; $display("FAIL ooo_same_cycle got=%b exp=0", commit_valid_o); end
    tick();
    clr_wr();
    total++; if (commit_valid_o !== 1'b1) begin bad++; $display("FAIL ooo_valid1 got=%b exp=1", commit_valid_o); end
    total++; if (commit_tag_o !== 6'd1) begin bad++; $display("FAIL ooo_tag1 got=%0d exp=1", commit_tag_o); end
    total++; if (commit_data_o !== 64'hA) begin bad++; $display("FAIL ooo_data1 got=%h exp=a", commit_data_o); end
    total++; if (commit_destReg_o !== 5'd5) begin bad++; $display("FAIL ooo_dest1 got=%0d exp=5", commit_destReg_o); end
    total++; if (count_o !== 6'd2) begin bad++; $display("FAIL ooo_count2 got=%0d exp=2", count_o); end
    commit_ready_i = 1'b1;
    tick();
    total++; if (commit_tag_o !== 6'd2 || commit_valid_o !== 1'b1) begin bad++; $display("FAIL ooo_tag2 got=%0d/%b exp=2/1", commit_tag_o, commit_valid_o); end
    total++; if (commit_data_o !== 64'hB) begin bad++; $display("FAIL ooo_data2 got=%h exp=b", commit_data_o); end
    total++; if (commit_destReg_o !== 5'd6) begin bad++; $display("FAIL ooo_dest2 got=%0d exp=6", commit_destReg_o); end
    total++; if (count_o !== 6'd1) begin bad++; $display("FAIL ooo_count1 got=%0d exp=1", count_o); end
    tick();
    commit_ready_i = 1'b0;
    total++; if (count_o !== 6'd0) begin bad++; $display("FAIL ooo_count0 got=%0d exp=0", count_o); end
    total++; if (commit_valid_o !== 1'b0) begin bad++; $display("FAIL ooo_empty_valid got=%b exp=0", commit_valid_o); end
  endtask

  task automatic test_flags();
    do_reset();
    alloc_one(5'd9, 1'b1);
    set_wr(6'd1, 64'h1234, 1'b1, 4'h0, 1'b0);
    tick();
    total++; if (commit_valid_o !== 1'b0) begin bad++; $display("FAIL flag_wait got=%b exp=0", commit_valid_o); end
    total++; if (commit_flagsWe_o !== 1'b0) begin bad++; $display("FAIL flag_we_early got=%b exp=0", commit_flagsWe_o); end
    set_wr(6'd1, 64'h1234, 1'b1, 4'b1001, 1'b1);
    tick();
    total++; if (commit_valid_o !== 1'b1) begin bad++; $display("FAIL flag_valid got=%b exp=1", commit_valid_o); end
    total++; if (commit_flagsWe_o !== 1'b1) begin bad++; $display("FAIL flag_we got=%b exp=1", commit_flagsWe_o); end
    total++; if (commit_flags_o !== 4'b1001) begin bad++; $display("FAIL flag_val got=%b exp=1001", commit_flags_o); end
    total++; if (commit_destReg_o !== 5'd9) begin bad++; $display("FAIL flag_dest got=%0d exp=9", commit_destReg_o); end
    set_wr(6'd1, 64'h5678, 1'b1, 4'b0000, 1'b0);
    tick();
    clr_wr();
    total++; if (commit_flags_o !== 4'b1001 || commit_flagsWe_o !== 1'b1) begin bad++; $display("FAIL flag_keep got=%b/%b exp=1001/1", commit_flags_o, commit_flagsWe_o); end
    total++; if (commit_data_o !== 64'h5678) begin bad++; $display("FAIL flag_data got=%h exp=5678", commit_data_o); end
  endtask

  task automatic test_full_wrap();
    do_reset();
    for (int i = 0; i < 32; i++) begin
      total++;
      if (alloc_tag_o !== 6'(i + 1)) begin bad++; $display("FAIL fill_tag%0d got=%0d exp=%0d", i, alloc_tag_o, i + 1); end
      alloc_one(5'(i), 1'b0);
    end
    total++; if (alloc_ready_o !== 1'b0) begin bad++; $display("FAIL full_ready got=%b exp=0", alloc_ready_o); end
    total++; if (count_o !== 6'd32) begin bad++; $display("FAIL full_count got=%0d exp=32", count_o); end
    alloc_one(5'd31, 1'b0);
    total++; if (count_o !== 6'd32) begin bad++; $display("FAIL full_ignore_count got=%0d exp=32", count_o); end
    total++; if (alloc_tag_o !== 6'd1) begin bad++; $display("FAIL full_ignore_tag got=%0d exp=1", alloc_tag_o); end
    set_wr(6'd1, 64'h11, 1'b1, 4'h0, 1'b0);
    tick();
    total++; if (commit_valid_o !== 1'b1 || commit_tag_o !== 6'd1) begin bad++; $display("FAIL full_head got=%b/%0d exp=1/1", commit_valid_o, commit_tag_o); end
    total++; if (commit_destReg_o !== 5'd0) begin bad++; $display("FAIL full_head_dest got=%0d exp=0", commit_destReg_o); end
    // retire tag 1 while completing tag 2 in the same cycle
    commit_ready_i = 1'b1;
    set_wr(6'd2, 64'h22, 1'b1, 4'h0, 1'b0);
    tick();
    clr_wr();
    total++; if (alloc_ready_o !== 1'b1) begin bad++; $display("FAIL wrap_ready got=%b exp=1", alloc_ready_o); end
    total++; if (alloc_tag_o !== 6'd1) begin bad++; $display("FAIL wrap_tag got=%0d exp=1", alloc_tag_o); end
    total++; if (count_o !== 6'd31) begin bad++; $display("FAIL wrap_count got=%0d exp=31", count_o); end
    total++; if (commit_valid_o !== 1'b1 || commit_tag_o !== 6'd2 || commit_data_o !== 64'h22) begin bad++; $display("FAIL wrap_head2 got=%b/%0d/%h exp=1/2/22", commit_valid_o, commit_tag_o, commit_data_o); end
    // allocate and retire together: count holds, both pointers move
    alloc_one(5'd20, 1'b0);
    commit_ready_i = 1'b0;
    total++; if (count_o !== 6'd31) begin bad++; $display("FAIL both_count got=%0d exp=31", count_o); end
    total++; if (alloc_tag_o !== 6'd2) begin bad++; $display("FAIL both_tail got=%0d exp=2", alloc_tag_o); end
    total++; if (commit_tag_o !== 6'd3 || commit_valid_o !== 1'b0) begin bad++; $display("FAIL both_head got=%0d/%b exp=3/0", commit_tag_o, commit_valid_o); end
    alloc_one(5'd21, 1'b0);
    total++; if (count_o !== 6'd32 || alloc_ready_o !== 1'b0) begin bad++; $display("FAIL refull got=%0d/%b exp=32/0", count_o, alloc_ready_o); end
  endtask

  task automatic test_illegal_writes();
    do_reset();
    alloc_one(5'd1, 1'b0);
    alloc_one(5'd2, 1'b0);
    set_wr(6'd0, 64'hDEAD, 1'b1, 4'hF, 1'b1);
    tick();
    total++; if (commit_valid_o !== 1'b0) begin bad++; $display("FAIL ill_tag0 got=%b exp=0", commit_valid_o); end
    set_wr(6'd7, 64'hBEEF, 1'b1, 4'hF, 1'b1);
    tick();
    total++; if (commit_valid_o !== 1'b0) begin bad++; $display("FAIL ill_tag7 got=%b exp=0", commit_valid_o); end
    set_wr(6'd33, 64'hCAFE, 1'b1, 4'hF, 1'b1);
    tick();
    clr_wr();
    total++; if (commit_valid_o !== 1'b0 || count_o !== 6'd2) begin bad++; $display("FAIL ill_range got=%b/%0d exp=0/2", commit_valid_o, count_o); end
    set_wr(6'd1, 64'h77, 1'b1, 4'h0, 1'b0);
    tick();
    clr_wr();
    total++; if (commit_valid_o !== 1'b1 || commit_data_o !== 64'h77) begin bad++; $display("FAIL ill_legal got=%b/%h exp=1/77", commit_valid_o, commit_data_o); end
  endtask

  task automatic test_flush();
    do_reset();
    for (int i = 0; i < 5; i++) alloc_one(5'(i + 10), 1'b0);
    set_wr(6'd1, 64'h99, 1'b1, 4'h0, 1'b0);
    tick();
    clr_wr();
    total++; if (commit_valid_o !== 1'b1 || count_o !== 6'd5) begin bad++; $display("FAIL preflush got=%b/%0d exp=1/5", commit_valid_o, count_o); end
    flush_i = 1'b1;
    alloc_valid_i = 1'b1;
    alloc_destReg_i = 5'd3;
    commit_ready_i = 1'b1;
    set_wr(6'd2, 64'h55, 1'b1, 4'h0, 1'b0);
    tick();
    idle();
    total++; if (count_o !== 6'd0) begin bad++; $display("FAIL flush_count got=%0d exp=0", count_o); end
    total++; if (alloc_tag_o !== 6'd1) begin bad++; $display("FAIL flush_tag got=%0d exp=1", alloc_tag_o); end
    total++; if (commit_valid_o !== 1'b0) begin bad++; $display("FAIL flush_cvalid got=%b exp=0", commit_valid_o); end
    alloc_one(5'd4, 1'b0);
    set_wr(6'd1, 64'h42, 1'b1, 4'h0, 1'b0);
    tick();
    clr_wr();
    for (int i = 0; i < 2; i++) begin
      total++;
      if (commit_valid_o !== 1'b1 || commit_tag_o !== 6'd1 || count_o !== 6'd1) begin
        bad++; $display("FAIL stall%0d got=%b/%0d/%0d exp=1/1/1", i, commit_valid_o, commit_tag_o, count_o);
      end
      tick();
    end
    total++; if (commit_data_o !== 64'h42 || commit_destReg_o !== 5'd4) begin bad++; $display("FAIL stall_data got=%h/%0d exp=42/4", commit_data_o, commit_destReg_o); end
  endtask

  initial begin
    reset_i = 1'b0;
    idle();
    test_reset();
    test_out_of_order();
    test_flags();
    test_full_wrap();
    test_illegal_writes();
    test_flush();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
